shot_clock_bcd: RTL and testbench
=================================

Name: shot_clock_bcd

Overview:
- Parametrised, fully synchronous BCD down-counter for the basketball shot/game clock; successor to the cascaded two-digit 24-second counter.
- Holds DIGITS BCD digits and counts down one unit per qualified tick.
- Supports full-preset reload, alternate-preset reload (e.g. 14 s) and arbitrary parallel load.
- Provides run/pause control, a one-cycle expiry pulse and a timed buzzer output. No derived or ripple clocks; every flop is on CP.

Parameters:
- DIGITS, 2, number of BCD digits; Q width is 4*DIGITS.
- PRESET, 'h24, full reload value, BCD-encoded.
- ALT_PRESET, 'h14, alternate reload value, BCD-encoded.
- BUZZ_TICKS, 3, number of ticks the buzzer stays on after expiry (1..15).

Ports:
- CP  in  1  system clock, rising edge.
- CR  in  1  synchronous reset, active-low.
- tick  in  1  one-cycle time-base enable (e.g. 1 Hz strobe).
- run  in  1  level: 1 = count, 0 = pause.
- rld_full  in  1  pulse: reload PRESET.
- rld_alt  in  1  pulse: reload ALT_PRESET.
- load  in  1  pulse: parallel load from D.
- D  in  4*DIGITS  BCD value for load.
- Q  out  4*DIGITS  current BCD count.
- zero  out  1  Q == 0.
- expire  out  1  one-cycle pulse when the count reaches 0 by counting.
- buzzer  out  1  buzzer drive.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.

Behaviour:
- Reset: CR sampled low at a CP edge gives Q=PRESET, state=IDLE, expire=0, buzzer=0, buzz counter=0. zero = (PRESET==0).
- Priority per cycle: CR > load > rld_full > rld_alt > count.
- Any load or reload:
  - Q takes the new value next edge.
  - Next state is RUN if run=1, else IDLE.
  - If the loaded value is 0, next state is EXPIRED with no expire pulse and no buzzer.
  - Buzzer and buzz counter clear.
  - A tick in the same cycle is ignored; no decrement.
- Load sanitising: any D nibble > 9 is stored as 9.
- State machine:
  - IDLE: run=1 -> RUN.
  - RUN: run=0 -> PAUSE; tick=1 with Q==1 -> EXPIRED.
  - PAUSE: run=1 -> RUN. Ticks are ignored.
  - EXPIRED: stays until load or reload. Ticks and run are ignored and Q holds 0.
- Count: in RUN with tick=1, Q decrements by 1 in BCD on the next edge.
  - Digit 0 borrows: becomes 9 and decrements the next-higher digit.
  - Latency from tick to new Q is 1 cycle.
  - Q never wraps below 0.
- run falling in the same cycle as a tick: the decrement happens and the state goes to PAUSE. The decision uses the state at the edge (RUN).
- Expiry: expire is registered and is high for exactly the one cycle in which Q first reads 0 and state reads EXPIRED.
- Buzzer:
  - Set in the same cycle as expire.
  - Stays high until BUZZ_TICKS further ticks have been seen, then clears on the edge after the last counted tick.
  - Cleared early by any load or reload.
- zero is combinational from Q.
- CR low mid-count: applies at the next edge regardless of tick/run/load.

Test Plan:
1. CR low 1 cycle, run=0 -> Q='h24, state=IDLE, zero=0, buzzer=0. Ticks while IDLE leave Q='h24.
2. run=1, 5 ticks -> Q='h19. Covers the borrow 'h20->'h19, each update exactly 1 cycle after its tick.
3. From 'h02 running, 2 ticks:
   - Q='h01, then 'h00; state=EXPIRED; expire high exactly 1 cycle.
   - buzzer high, then low after 3 more ticks.
   - Extra ticks keep Q='h00.
4. Running at 'h09:
   - run=0 gives PAUSE; 3 ticks leave Q='h09.
   - run=1 with tick in the same cycle -> Q stays 'h09 that edge (state was PAUSE), 'h08 on the next tick.
5. Same cycle load=1 (D='h3F), rld_full=1, tick=1 -> Q='h39, no decrement.
   - Next cycle rld_alt=1 with run=1 -> Q='h14, state=RUN.
6. EXPIRED with buzzer high, rld_full=1 -> buzzer low next edge, Q='h24. Then CR low during RUN -> Q='h24, state=IDLE.

Source files
------------

// File: rtl/shot_clock_bcd.sv
// Shot/game clock: parametrised BCD down-counter with run/pause control,
// full/alternate preset reload, sanitised parallel load, a one-cycle expiry
// pulse and a buzzer that stays on for a fixed number of ticks after expiry.
// Every flop is clocked by CP; tick is used only as an enable.
module shot_clock_bcd #(
  parameter int                  DIGITS     = 2,
  parameter logic [4*DIGITS-1:0] PRESET     = 'h24,
  parameter logic [4*DIGITS-1:0] ALT_PRESET = 'h14,
  parameter int                  BUZZ_TICKS = 3
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  rld_full,
  input  logic                  rld_alt,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  zero,
  output logic                  expire,
  output logic                  buzzer,
  output logic [1:0]            state
);

  localparam int             W        = 4 * DIGITS;
  localparam logic [W-1:0]   ONE      = W'(1);
  localparam logic [3:0]     BUZZ_LIM = 4'(BUZZ_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         expire_q, expire_d;
  logic         buzzer_q, buzzer_d;
  logic [3:0]   buzz_cnt_q, buzz_cnt_d;

  logic         load_any;
  logic [W-1:0] load_val;

  // Clamp every nibble above 9 down to 9 so the count stays valid BCD.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD decrement by one; a zero digit becomes 9 and borrows from the next.
  // Callers guarantee v is non-zero, so the result never wraps.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_any = load | rld_full | rld_alt;
  assign load_val = load     ? sanitize(D) :
                    rld_full ? PRESET      : ALT_PRESET;

  // Next-state, count, expiry and buzzer logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    q_d        = q_q;
    expire_d   = 1'b0;
    buzzer_d   = buzzer_q;
    buzz_cnt_d = buzz_cnt_q;

    if (load_any) begin
      // Loads win over counting; a tick in the same cycle is dropped.
      q_d        = load_val;
      buzzer_d   = 1'b0;
      buzz_cnt_d = 4'd0;
      if (load_val == '0) state_d = ST_EXPIRED;
      else if (run)       state_d = ST_RUN;
      else                state_d = ST_IDLE;
    end else begin
      // Buzzer counts ticks after expiry and drops on the last one.
      if (buzzer_q && tick) begin
        if (buzz_cnt_q + 4'd1 == BUZZ_LIM) begin
          buzzer_d   = 1'b0;
          buzz_cnt_d = 4'd0;
        end else begin
          buzz_cnt_d = buzz_cnt_q + 4'd1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick && q_q != '0) begin
            q_d = bcd_dec(q_q);
            if (q_q == ONE) begin
              state_d    = ST_EXPIRED;
              expire_d   = 1'b1;
              buzzer_d   = 1'b1;
              buzz_cnt_d = 4'd0;
            end else if (!run) begin
              state_d = ST_PAUSE;
            end
          end else if (!run) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (run) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CP) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!CR) begin
      state_q    <= ST_IDLE;
      q_q        <= PRESET;
      expire_q   <= 1'b0;
      buzzer_q   <= 1'b0;
      buzz_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      expire_q   <= expire_d;
      buzzer_q   <= buzzer_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

  assign Q      = q_q;
  assign zero   = (q_q == '0);
  assign expire = expire_q;
  assign buzzer = buzzer_q;
  assign state  = state_q;

endmodule

// File: tb/tb_shot_clock_bcd.sv
// Directed self-checking bench for shot_clock_bcd with default parameters
// (two digits, PRESET 'h24, ALT_PRESET 'h14, BUZZ_TICKS 3).
module tb_shot_clock_bcd;

  logic       CP;
  logic       CR;
  logic       tick;
  logic       run;
  logic       rld_full;
  logic       rld_alt;
  logic       load;
  logic [7:0] D;
  logic [7:0] Q;
  logic       zero;
  logic       expire;
  logic       buzzer;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXP = 2'd3;

  shot_clock_bcd dut (
    .CP       (CP),
    .CR       (CR),
    .tick     (tick),
    .run      (run),
    .rld_full (rld_full),
    .rld_alt  (rld_alt),
    .load     (load),
    .D        (D),
    .Q        (Q),
    .zero     (zero),
    .expire   (expire),
    .buzzer   (buzzer),
    .state    (state)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  initial begin
    CR = 1'b0; tick = 1'b0; run = 1'b0;
    rld_full = 1'b0; rld_alt = 1'b0; load = 1'b0; D = 8'h00;

    // 1: reset and idle ticks
    step();
    check("rst_q",      32'(Q), 32'h24);
    check("rst_state",  32'(state), 32'(S_IDLE));
    check("rst_zero",   32'(zero), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_expire", 32'(expire), 32'd0);
    CR = 1'b1;
    tick = 1'b1; step();
    tick = 1'b0; step();
    check("idle_tick_q",     32'(Q), 32'h24);
    check("idle_tick_state", 32'(state), 32'(S_IDLE));

    // 2: run and count 24 -> 19 with borrow
    run = 1'b1; step();
    check("run_state", 32'(state), 32'(S_RUN));
    begin
      logic [7:0] exp_seq [5];
      exp_seq = '{8'h23, 8'h22, 8'h21, 8'h20, 8'h19};
      for (int i = 0; i < 5; i++) begin
        tick = 1'b1; step();
        check("count_q", 32'(Q), 32'(exp_seq[i]));
        tick = 1'b0; step();
        check("count_hold", 32'(Q), 32'(exp_seq[i]));
      end
    end

    // 3: expiry from 02, expire pulse, buzzer for 3 ticks
    D = 8'h02; load = 1'b1; step(); load = 1'b0;
    check("ld02_q",     32'(Q), 32'h02);
    check("ld02_state", 32'(state), 32'(S_RUN));
    tick = 1'b1; step();
    check("exp_q01",     32'(Q), 32'h01);
    check("exp_no_pls",  32'(expire), 32'd0);
    step();
    check("exp_q00",     32'(Q), 32'h00);
    check("exp_state",   32'(state), 32'(S_EXP));
    check("exp_pulse",   32'(expire), 32'd1);
    check("exp_zero",    32'(zero), 32'd1);
    check("exp_buzz_on", 32'(buzzer), 32'd1);
    tick = 1'b0; step();
    check("exp_pulse_end", 32'(expire), 32'd0);
    check("buzz_hold",     32'(buzzer), 32'd1);
    tick = 1'b1; step(); tick = 1'b0;
    check("buzz_t1", 32'(buzzer), 32'd1);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check("buzz_t2", 32'(buzzer), 32'd1);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check("buzz_t3_off", 32'(buzzer), 32'd0);
    run = 1'b0;
    tick = 1'b1; step(); step(); tick = 1'b0;
    check("exp_stay_q",     32'(Q), 32'h00);
    check("exp_stay_state", 32'(state), 32'(S_EXP));
    check("exp_stay_pulse", 32'(expire), 32'd0);

    // 4: pause handling from 09
    run = 1'b1; D = 8'h09; load = 1'b1; step(); load = 1'b0;
    check("ld09_q", 32'(Q), 32'h09);
    run = 1'b0; step();
    check("pause_state", 32'(state), 32'(S_PAUSE));
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; step();
    end
    tick = 1'b0;
    check("pause_q", 32'(Q), 32'h09);
    run = 1'b1; tick = 1'b1; step();
    check("resume_q",     32'(Q), 32'h09);
    check("resume_state", 32'(state), 32'(S_RUN));
    step();
    check("resume_dec", 32'(Q), 32'h08);
    run = 1'b0; step(); tick = 1'b0;
    check("runfall_q",     32'(Q), 32'h07);
    check("runfall_state", 32'(state), 32'(S_PAUSE));

    // 5: load priority and sanitising, then alternate reload
    D = 8'h3F; load = 1'b1; rld_full = 1'b1; tick = 1'b1; step();
    load = 1'b0; rld_full = 1'b0; tick = 1'b0;
    check("prio_q",     32'(Q), 32'h39);
    check("prio_state", 32'(state), 32'(S_IDLE));
    rld_alt = 1'b1; run = 1'b1; step(); rld_alt = 1'b0;
    check("alt_q",     32'(Q), 32'h14);
    check("alt_state", 32'(state), 32'(S_RUN));
    D = 8'hA5; load = 1'b1; step(); load = 1'b0;
    check("sanit_hi_q", 32'(Q), 32'h95);

    // 6: reload out of expiry, reset mid-run, load of zero
    D = 8'h01; load = 1'b1; step(); load = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    check("e6_state",  32'(state), 32'(S_EXP));
    check("e6_buzzer", 32'(buzzer), 32'd1);
    rld_full = 1'b1; step(); rld_full = 1'b0;
    check("rfull_buzz",  32'(buzzer), 32'd0);
    check("rfull_q",     32'(Q), 32'h24);
    check("rfull_state", 32'(state), 32'(S_RUN));
    tick = 1'b1; step();
    check("rfull_dec", 32'(Q), 32'h23);
    CR = 1'b0; step(); CR = 1'b1; tick = 1'b0;
    check("midrst_q",     32'(Q), 32'h24);
    check("midrst_state", 32'(state), 32'(S_IDLE));
    D = 8'h00; load = 1'b1; step(); load = 1'b0;
    check("ld0_state",  32'(state), 32'(S_EXP));
    check("ld0_expire", 32'(expire), 32'd0);
    check("ld0_buzzer", 32'(buzzer), 32'd0);
    check("ld0_zero",   32'(zero), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
